// File: rtl/instr_sequencer.sv
// Purpose: fetches 32-bit words from a small loadable instruction store and issues them to a processor over a valid/ready link.
// Latency: start -> FETCH next cycle -> instruction/instr_valid registered one cycle later; at best one issue every 2 cycles.
// Backpressure: instr_ready=0 holds the instruction and instr_valid stable in ISSUE; loads and starts are ignored while busy.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          abort,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic [7:0]    issue_count
);

    localparam logic [5:0]    HALT_OP = 6'b111111;
    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [31:0] fetch_word;

    // Status flags come straight from the state register.
    assign busy       = (state == ST_FETCH) || (state == ST_ISSUE);
    assign halted     = (state == ST_HALT);
    assign fetch_word = mem[pc];

    // Instruction store: writable only when idle or halted; reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (reset && load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    // Sequencer FSM with registered outputs; reset beats abort, abort beats start and handshakes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            instruction <= 32'd0;
            instr_valid <= 1'b0;
            pc          <= '0;
            issue_count <= 8'd0;
        end else if (abort) begin
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        issue_count <= 8'd0;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // The halt word is captured but never presented as valid.
                    instruction <= fetch_word;
                    if (fetch_word[31:26] == HALT_OP) begin
                        state <= ST_HALT;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (issue_count != 8'hFF) begin
                            issue_count <= issue_count + 8'd1;
                        end
                        // Last entry stops the program rather than wrapping to 0.
                        if (pc == LAST_PC) begin
                            state <= ST_HALT;
                        end else begin
                            pc    <= pc + AW'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: self-checking bench for instr_sequencer using a vector table plus directed multi-cycle sequences.
// Latency: inputs driven 1 time unit after a rising edge, outputs compared 1 time unit after the next edge.
// Backpressure: instr_ready driven directly from the vectors and sequences.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [31:0] I_ADD  = 32'h00080000;
    localparam logic [31:0] I_SUB  = 32'h04080000;
    localparam logic [31:0] I_OR   = 32'h0C080000;
    localparam logic [31:0] I_HALT = 32'hFC000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic          abort;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic [7:0]    issue_count;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .abort       (abort),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          ld;
        logic [AW-1:0] la;
        logic [31:0]   ldd;
        logic          st;
        logic          ab;
        logic          rdy;
        logic [31:0]   e_ins;
        logic          e_vld;
        logic [AW-1:0] e_pc;
        logic          e_busy;
        logic          e_halt;
        logic [7:0]    e_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ins, input logic vld,
                             input logic [AW-1:0] p, input logic b, input logic h,
                             input logic [7:0] c);
        chk({tag, ".instruction"}, instruction, ins);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(vld));
        chk({tag, ".pc"}, 32'(pc), 32'(p));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".halted"}, 32'(halted), 32'(h));
        chk({tag, ".issue_count"}, 32'(issue_count), 32'(c));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (halted) break;
            step();
        end
        chk({tag, ".halt_reached"}, 32'(halted), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = 32'd0;
        start = 1'b0; abort = 1'b0; instr_ready = 1'b0;

        //          rst  ld    la     data    st    ab    rdy   ins     vld   pc     busy  halt  cnt
        tbl[0]  = '{1'b0, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 4'd0, I_ADD,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 4'd1, I_SUB,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 4'd2, I_OR,   1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 4'd3, I_HALT, 1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_ADD,  1'b1, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_ADD,  1'b0, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_SUB,  1'b1, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_SUB,  1'b0, 4'd2, 1'b1, 1'b0, 8'd2};
        tbl[9]  = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_OR,   1'b1, 4'd2, 1'b1, 1'b0, 8'd2};
        tbl[10] = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_OR,   1'b0, 4'd3, 1'b1, 1'b0, 8'd3};
        tbl[11] = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_HALT, 1'b0, 4'd3, 1'b0, 1'b1, 8'd3};
        tbl[12] = '{1'b1, 1'b0, 4'd0, 32'd0,  1'b0, 1'b0, 1'b1, I_HALT, 1'b0, 4'd3, 1'b0, 1'b1, 8'd3};

        // Reset state, program load, three issues at 2-cycle spacing, then halt.
        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst_n; load_en = tbl[i].ld; load_addr = tbl[i].la;
            load_data = tbl[i].ldd; start = tbl[i].st; abort = tbl[i].ab;
            instr_ready = tbl[i].rdy;
            step();
            check_all($sformatf("vec%0d", i), tbl[i].e_ins, tbl[i].e_vld, tbl[i].e_pc,
                      tbl[i].e_busy, tbl[i].e_halt, tbl[i].e_cnt);
        end
        load_en = 1'b0; start = 1'b0;

        // Stall on SUB for 5 cycles, with a start ignored mid-stall.
        start = 1'b1; instr_ready = 1'b0;
        step();
        start = 1'b0;
        check_all("stall_start", I_HALT, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0);
        step();
        check_all("stall_add", I_ADD, 1'b1, 4'd0, 1'b1, 1'b0, 8'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        check_all("stall_sub", I_SUB, 1'b1, 4'd1, 1'b1, 1'b0, 8'd1);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            step();
            check_all($sformatf("stall%0d", k), I_SUB, 1'b1, 4'd1, 1'b1, 1'b0, 8'd1);
        end
        start = 1'b0; instr_ready = 1'b1;
        step();
        check_all("stall_release", I_SUB, 1'b0, 4'd2, 1'b1, 1'b0, 8'd2);
        run_to_halt("stall_run", 20);
        chk("stall_final_count", 32'(issue_count), 32'd3);
        chk("stall_final_pc", 32'(pc), 32'd3);

        // Abort coincident with a handshake: idle, nothing counted.
        start = 1'b1; instr_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("abort_pre_valid", 32'(instr_valid), 32'd1);
        abort = 1'b1; instr_ready = 1'b1;
        step();
        abort = 1'b0; instr_ready = 1'b0;
        check_all("abort", I_ADD, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        step();
        check_all("abort_idle", I_ADD, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Writes while busy must not land; verified by a fresh run.
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0;
        load_en = 1'b1; load_addr = 4'd1; load_data = 32'hDEADBEEF;
        repeat (3) step();
        load_en = 1'b0;
        check_all("busy_load_issue", I_SUB, 1'b1, 4'd1, 1'b1, 1'b0, 8'd1);
        run_to_halt("busy_load_run", 20);
        chk("busy_load_count", 32'(issue_count), 32'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check_all("busy_load_restart", I_SUB, 1'b1, 4'd1, 1'b1, 1'b0, 8'd1);

        // One-cycle reset mid-ISSUE, then restart from entry 0.
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_all("midreset", 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("midreset_fetch", 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0);
        step();
        check_all("midreset_issue", I_ADD, 1'b1, 4'd0, 1'b1, 1'b0, 8'd0);

        // Full store of ADDs: 16 issues, halt at pc=15 without wrapping.
        abort = 1'b1;
        step();
        abort = 1'b0; instr_ready = 1'b0;
        chk("full_idle_busy", 32'(busy), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            load_en = 1'b1; load_addr = AW'(a); load_data = I_ADD;
            step();
        end
        load_en = 1'b0;
        start = 1'b1; instr_ready = 1'b1;
        step();
        start = 1'b0;
        run_to_halt("full_run", 60);
        check_all("full_halt", I_ADD, 1'b0, 4'd15, 1'b0, 1'b1, 8'd16);
        repeat (3) step();
        check_all("full_hold", I_ADD, 1'b0, 4'd15, 1'b0, 1'b1, 8'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: the number of instruction memory entries, which must be a power of two.
REQ-002 The block SHALL have parameter AW, default 4: the address and pc width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port load_en, input, 1 bit: instruction memory write strobe.
REQ-006 The block SHALL have port load_addr, input, AW bits: memory write address.
REQ-007 The block SHALL have port load_data, input, 32 bits: memory write data.
REQ-008 The block SHALL have port start, input, 1 bit: a one-cycle request to begin issuing at address 0.
REQ-009 The block SHALL have port abort, input, 1 bit: a one-cycle request to stop and return to IDLE.
REQ-010 The block SHALL have port instruction, output, 32 bits: the instruction issued to the processor; opcode is in [31:26].
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instruction holds a valid item.
REQ-012 The block SHALL have port instr_ready, input, 1 bit: the processor accepts instruction.
REQ-013 The block SHALL have port pc, output, AW bits: the address of the current or next fetch.
REQ-014 The block SHALL have port busy, output, 1 bit: high in FETCH or ISSUE.
REQ-015 The block SHALL have port halted, output, 1 bit: high in HALT.
REQ-016 The block SHALL have port issue_count, output, 8 bits: the number of completed handshakes since the last start.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, ISSUE and HALT.
REQ-018 In IDLE, start=1 SHALL set pc=0 and issue_count=0, with state FETCH on the next cycle.
REQ-019 In FETCH, the memory entry at pc SHALL be registered into instruction at the cycle end.
- If its opcode is 6'b111111, the next state SHALL be HALT and the entry SHALL NOT be issued.
- Otherwise the next state SHALL be ISSUE.
REQ-020 In ISSUE, instr_valid SHALL be 1, and instruction SHALL stay stable while instr_ready=0.
REQ-021 A handshake SHALL be the rising edge with instr_valid=1 and instr_ready=1.
- issue_count increments, saturating at 255.
- If pc==DEPTH-1, the next state is HALT with pc unchanged (no wrap-around).
- Otherwise pc increments and the next state is FETCH.
REQ-022 Peak throughput SHALL be one instruction per 2 cycles, with instr_valid=0 during FETCH.
REQ-023 In HALT, start=1 SHALL behave exactly as REQ-018.
REQ-024 In HALT, pc, instruction and issue_count SHALL hold.
REQ-025 abort=1 in any state SHALL force IDLE on the next cycle.
- instr_valid is deasserted.
- pc, instruction and issue_count hold.
- abort has priority over start and over a coincident handshake; that handshake is not counted.
REQ-026 A memory write SHALL occur when load_en=1 and busy=0; load_en while busy=1 SHALL be ignored.
REQ-027 load_en and start SHALL be able to act in the same IDLE or HALT cycle: the write completes, and the later FETCH reads the new data.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 busy and halted SHALL be decoded from the state register only; instr_valid SHALL be registered.

Reset
REQ-030 With reset=0 at a rising edge, the block SHALL enter IDLE and drive instruction=0, instr_valid=0, pc=0, busy=0, halted=0 and issue_count=0.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Reset asserted mid-ISSUE SHALL drop instr_valid on the next edge, with no handshake counted.
REQ-033 Reset SHALL have priority over abort, start and load_en.

Verification
REQ-034 Load {ADD 32'h00080000, SUB 32'h04080000, OR 32'h0C080000, 32'hFC000000}, hold instr_ready=1, pulse start -> the three instructions issue in order at 2-cycle spacing, then HALT with issue_count=3 and pc=3.
REQ-035 Set instr_ready=0 for 5 cycles during ISSUE of SUB -> instruction holds 32'h04080000 with instr_valid=1 throughout, and exactly one count is added when ready rises.
REQ-036 Fill all 16 entries with ADD, no halt opcode, start -> 16 handshakes, then halted=1 with pc=15 and no wrap to 0.
REQ-037 Pulse abort in the same cycle as a handshake -> IDLE next cycle, instr_valid=0, and issue_count not incremented.
REQ-038 Drive load_en while busy to overwrite entry 1 -> entry 1 unchanged, checked by issue after restart.
REQ-039 Drive reset=0 for one cycle during ISSUE -> all outputs take their REQ-030 values next cycle; a following start re-issues entry 0.
